// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing checker: recovers x/y, measures line/frame timing, locks, counts lock losses, probes one pixel.
// Latency: outputs move one board_clk after the pix_ce that sampled the input; no backpressure, pix_ce low freezes everything.
module vga_sync_monitor #(
    parameter int H_TOTAL  = 800,
    parameter int H_SYNC   = 96,
    parameter int V_TOTAL  = 525,
    parameter int V_SYNC   = 2,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        board_clk,
    input  logic        reset,
    input  logic        pix_ce,
    input  logic        vga_h_sync,
    input  logic        vga_v_sync,
    input  logic [2:0]  vga_rgb,
    input  logic [10:0] probe_x,
    input  logic [10:0] probe_y,
    input  logic        clear_err,
    output logic [10:0] rx_x,
    output logic [10:0] rx_y,
    output logic        locked,
    output logic [10:0] h_meas,
    output logic [10:0] v_meas,
    output logic [2:0]  probe_rgb,
    output logic        probe_valid,
    output logic [3:0]  err_flags,
    output logic [7:0]  err_count
);

    localparam logic [10:0] CNT_MAX   = 11'h7FF;
    localparam logic [10:0] H_TOTAL_C = 11'(H_TOTAL);
    localparam logic [10:0] H_SYNC_C  = 11'(H_SYNC);
    localparam logic [10:0] V_TOTAL_C = 11'(V_TOTAL);
    localparam logic [10:0] V_SYNC_C  = 11'(V_SYNC);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == CNT_MAX) ? v : v + 11'd1;
    endfunction

    logic       h_cur, h_prev, v_cur, v_prev;
    logic [2:0] rgb_cur;
    logic       step;

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            h_cur   <= ~SYNC_POL;
            h_prev  <= ~SYNC_POL;
            v_cur   <= ~SYNC_POL;
            v_prev  <= ~SYNC_POL;
            rgb_cur <= 3'b000;
            step    <= 1'b0;
        end else begin
            step <= pix_ce;
            if (pix_ce) begin
                h_cur   <= vga_h_sync;
                h_prev  <= h_cur;
                v_cur   <= vga_v_sync;
                v_prev  <= v_cur;
                rgb_cur <= vga_rgb;
            end
        end
    end

    // Edges are acted on in the cycle after the sampling pix_ce, while both history stages are stable.
    logic h_on, h_was, v_on, v_was;
    logic h_rise, h_fall, v_rise, v_fall;

    assign h_on   = (h_cur == SYNC_POL);
    assign h_was  = (h_prev == SYNC_POL);
    assign v_on   = (v_cur == SYNC_POL);
    assign v_was  = (v_prev == SYNC_POL);
    assign h_rise = step && h_on && !h_was;
    assign h_fall = step && !h_on && h_was;
    assign v_rise = step && v_on && !v_was;
    assign v_fall = step && !v_on && v_was;

    logic [10:0] h_wcnt, v_wcnt;
    logic [10:0] h_len, v_len;
    logic [10:0] x_next, y_next;

    assign h_len  = sat_inc(rx_x);
    assign v_len  = h_rise ? sat_inc(rx_y) : rx_y;
    assign x_next = h_rise ? 11'd0 : sat_inc(rx_x);
    assign y_next = v_rise ? 11'd0 : (h_rise ? sat_inc(rx_y) : rx_y);

    // A counter stuck at its ceiling never counts as a valid measurement.
    logic       htot_bad, hwid_bad, vtot_bad, vwid_bad, any_bad;
    logic [3:0] bad;

    assign htot_bad = h_rise && ((rx_x == CNT_MAX) || (h_len != H_TOTAL_C));
    assign hwid_bad = h_fall && ((h_wcnt == CNT_MAX) || (h_wcnt != H_SYNC_C));
    assign vtot_bad = v_rise && ((v_len == CNT_MAX) || (v_len != V_TOTAL_C));
    assign vwid_bad = v_fall && ((v_wcnt == CNT_MAX) || (v_wcnt != V_SYNC_C));
    assign bad      = {vwid_bad, vtot_bad, hwid_bad, htot_bad};
    assign any_bad  = |bad;

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            rx_x        <= 11'd0;
            rx_y        <= 11'd0;
            h_wcnt      <= 11'd0;
            v_wcnt      <= 11'd0;
            h_meas      <= 11'd0;
            v_meas      <= 11'd0;
            probe_rgb   <= 3'b000;
            probe_valid <= 1'b0;
        end else begin
            probe_valid <= 1'b0;
            if (step) begin
                rx_x <= x_next;
                rx_y <= y_next;
                if (h_rise) begin
                    h_meas <= h_len;
                    h_wcnt <= 11'd1;
                end else if (h_on) begin
                    h_wcnt <= sat_inc(h_wcnt);
                end
                // vsync width is counted in lines: hsync asserts seen while vsync is asserted.
                if (v_rise) begin
                    v_meas <= v_len;
                    v_wcnt <= h_rise ? 11'd1 : 11'd0;
                end else if (h_rise && v_on) begin
                    v_wcnt <= sat_inc(v_wcnt);
                end
                if ((x_next == probe_x) && (y_next == probe_y)) begin
                    probe_rgb   <= rgb_cur;
                    probe_valid <= 1'b1;
                end
            end
        end
    end

    state_t state;
    logic   frame_ok;

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state     <= UNLOCKED;
            frame_ok  <= 1'b0;
            locked    <= 1'b0;
            err_flags <= 4'b0000;
            err_count <= 8'd0;
        end else begin
            if ((state == LOCKED) && any_bad) begin
                err_flags <= (clear_err ? 4'b0000 : err_flags) | bad;
                err_count <= clear_err ? 8'd1 :
                             ((err_count == 8'hFF) ? 8'hFF : err_count + 8'd1);
            end else if (clear_err) begin
                err_flags <= 4'b0000;
                err_count <= 8'd0;
            end

            case (state)
                UNLOCKED: begin
                    locked <= 1'b0;
                    // The frame begun here follows an unqualified partial frame, so it is not eligible.
                    if (v_rise) begin
                        state    <= ACQUIRE;
                        frame_ok <= 1'b0;
                    end
                end
                ACQUIRE: begin
                    if (v_rise) begin
                        if (frame_ok && !any_bad) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                        frame_ok <= 1'b1;
                    end else if (any_bad) begin
                        frame_ok <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (any_bad) begin
                        state    <= UNLOCKED;
                        locked   <= 1'b0;
                        frame_ok <= 1'b0;
                    end
                end
                default: begin
                    state    <= UNLOCKED;
                    locked   <= 1'b0;
                    frame_ok <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor on a reduced 40x20 raster (sync 6/2) so whole frames fit a short run.
module tb_vga_sync_monitor;

    localparam int TB_HT = 40;
    localparam int TB_HS = 6;
    localparam int TB_VT = 20;
    localparam int TB_VS = 2;
    localparam int BAR_X = 10;
    localparam int BAR_Y = 12;

    logic        board_clk = 1'b0;
    logic        reset;
    logic        pix_ce;
    logic        vga_h_sync;
    logic        vga_v_sync;
    logic [2:0]  vga_rgb;
    logic [10:0] probe_x;
    logic [10:0] probe_y;
    logic        clear_err;
    logic [10:0] rx_x;
    logic [10:0] rx_y;
    logic        locked;
    logic [10:0] h_meas;
    logic [10:0] v_meas;
    logic [2:0]  probe_rgb;
    logic        probe_valid;
    logic [3:0]  err_flags;
    logic [7:0]  err_count;

    vga_sync_monitor #(
        .H_TOTAL(TB_HT), .H_SYNC(TB_HS), .V_TOTAL(TB_VT), .V_SYNC(TB_VS), .SYNC_POL(1'b0)
    ) dut (
        .board_clk(board_clk), .reset(reset), .pix_ce(pix_ce),
        .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync), .vga_rgb(vga_rgb),
        .probe_x(probe_x), .probe_y(probe_y), .clear_err(clear_err),
        .rx_x(rx_x), .rx_y(rx_y), .locked(locked), .h_meas(h_meas), .v_meas(v_meas),
        .probe_rgb(probe_rgb), .probe_valid(probe_valid),
        .err_flags(err_flags), .err_count(err_count)
    );

    always #5 board_clk = ~board_clk;

    int n_vec = 0;
    int n_bad = 0;
    int pv_cnt = 0;

    int g_line = 0, g_px = 0, wraps = 0;
    int vs_w = TB_VS;
    int long_line = -1;
    int clr_line = -1, clr_px = -1;
    int ce_div = 1;

    always @(negedge board_clk) if (probe_valid) pv_cnt = pv_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One generated pixel: syncs are active-low, bar pixel at (BAR_X,BAR_Y) is green.
    task automatic drive_one();
        logic       hs_a, vs_a;
        logic [2:0] rgb;
        int         len;
        hs_a = (g_px < TB_HS);
        vs_a = (g_line < vs_w);
        rgb  = (g_line == BAR_Y && g_px == BAR_X) ? 3'b010 : (3'(g_px) ^ 3'(g_line));
        vga_h_sync = ~hs_a;
        vga_v_sync = ~vs_a;
        vga_rgb    = rgb;
        clear_err  = (g_line == clr_line && g_px == clr_px);
        pix_ce     = 1'b1;
        @(posedge board_clk); #1;
        pix_ce    = 1'b0;
        clear_err = 1'b0;
        for (int i = 1; i < ce_div; i++) begin
            @(posedge board_clk); #1;
        end
        len = TB_HT + ((g_line == long_line) ? 1 : 0);
        g_px++;
        if (g_px >= len) begin
            g_px = 0;
            g_line++;
            if (g_line >= TB_VT) begin
                g_line = 0;
                wraps++;
            end
        end
    endtask

    // Drive pixels until `frames` wraps have occurred and (line,px) is the next pixel to drive.
    task automatic advance(input int frames, input int line, input int px);
        int start;
        int n;
        start = wraps;
        n = 0;
        while (!((wraps - start) >= frames && g_line == line && g_px == px)) begin
            drive_one();
            n++;
            if (n > 100000) begin
                $display("FAIL advance_bound: got %0d pixels expected fewer", n);
                $fatal(1);
            end
        end
    endtask

    task automatic restart_gen();
        g_line = 0;
        g_px   = 0;
        wraps  = 0;
    endtask

    initial begin
        reset      = 1'b1;
        pix_ce     = 1'b0;
        vga_h_sync = 1'b1;
        vga_v_sync = 1'b1;
        vga_rgb    = 3'b000;
        probe_x    = 11'(BAR_X);
        probe_y    = 11'(BAR_Y);
        clear_err  = 1'b0;
        repeat (3) @(posedge board_clk);
        #1;
        chk("rst_rx_x", 32'(rx_x), 0);
        chk("rst_rx_y", 32'(rx_y), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_h_meas", 32'(h_meas), 0);
        chk("rst_v_meas", 32'(v_meas), 0);
        chk("rst_probe", 32'({probe_valid, probe_rgb}), 0);
        chk("rst_err", 32'({err_count, err_flags}), 0);
        reset = 1'b0;

        // Ideal timing: lock lands one cycle after the third vsync assert.
        restart_gen();
        advance(2, 0, 1);
        chk("t1_not_yet", 32'(locked), 0);
        advance(0, 0, 2);
        chk("t1_locked", 32'(locked), 1);
        chk("t1_h_meas", 32'(h_meas), TB_HT);
        chk("t1_v_meas", 32'(v_meas), TB_VT);
        chk("t1_err", 32'(err_flags), 0);
        chk("t1_rx_x", 32'(rx_x), 0);
        chk("t1_rx_y", 32'(rx_y), 0);

        // One line one clock too long.
        long_line = 5;
        advance(0, 6, 1);
        chk("t2_pre_locked", 32'(locked), 1);
        advance(0, 6, 2);
        chk("t2_locked", 32'(locked), 0);
        chk("t2_flags", 32'(err_flags), 32'b0001);
        chk("t2_count", 32'(err_count), 1);
        chk("t2_h_meas", 32'(h_meas), TB_HT + 1);
        long_line = -1;
        advance(3, 0, 1);
        chk("t2_relock_pre", 32'(locked), 0);
        advance(0, 0, 2);
        chk("t2_relock", 32'(locked), 1);
        chk("t2_sticky", 32'(err_flags), 32'b0001);

        // Plain clear, then a 3-line vsync in a locked frame.
        clr_line = 0;
        clr_px   = 3;
        advance(0, 0, 4);
        clr_line = -1;
        chk("t3_clr_flags", 32'(err_flags), 0);
        chk("t3_clr_count", 32'(err_count), 0);
        vs_w = 3;
        advance(0, 3, 2);
        chk("t3_vw_flags", 32'(err_flags), 32'b1000);
        chk("t3_vw_count", 32'(err_count), 1);
        chk("t3_vw_locked", 32'(locked), 0);
        vs_w = TB_VS;
        advance(3, 0, 2);
        chk("t3_relock", 32'(locked), 1);

        // clear_err lands in the same cycle as an htotal error: the error wins.
        long_line = 5;
        clr_line  = 6;
        clr_px    = 1;
        advance(0, 6, 2);
        long_line = -1;
        clr_line  = -1;
        chk("t3_clr_err_flags", 32'(err_flags), 32'b0001);
        chk("t3_clr_err_count", 32'(err_count), 1);

        // Probe on the bar pixel, then on a pattern pixel.
        pv_cnt = 0;
        advance(1, 6, 2);
        chk("t4_bar_pulses", 32'(pv_cnt), 1);
        chk("t4_bar_rgb", 32'(probe_rgb), 32'b010);
        probe_x = 11'd5;
        probe_y = 11'd2;
        pv_cnt  = 0;
        advance(1, 6, 2);
        chk("t4_pat_pulses", 32'(pv_cnt), 1);
        chk("t4_pat_rgb", 32'(probe_rgb), 32'b111);
        advance(1, 8, 0);
        chk("t6_locked_before", 32'(locked), 1);

        // Asynchronous reset mid-frame.
        reset = 1'b1;
        #1;
        chk("t6_rst_locked", 32'(locked), 0);
        chk("t6_rst_meas", 32'({h_meas, v_meas}), 0);
        chk("t6_rst_rx", 32'({rx_x, rx_y}), 0);
        chk("t6_rst_err", 32'({err_count, err_flags}), 0);
        @(posedge board_clk); #1;
        reset = 1'b0;

        // Same acquisition with pix_ce every fourth clock.
        ce_div = 4;
        restart_gen();
        advance(2, 0, 0);
        chk("t6_slow_not_yet", 32'(locked), 0);
        advance(0, 0, 1);
        chk("t6_slow_locked", 32'(locked), 1);
        chk("t6_slow_h_meas", 32'(h_meas), TB_HT);
        chk("t6_slow_v_meas", 32'(v_meas), TB_VT);
        chk("t6_slow_err", 32'(err_flags), 0);

        // No syncs at all after a reset: column counter saturates, nothing locks or errors.
        ce_div = 1;
        reset  = 1'b1;
        @(posedge board_clk); #1;
        reset = 1'b0;
        vga_h_sync = 1'b1;
        vga_v_sync = 1'b1;
        vga_rgb    = 3'b000;
        for (int i = 0; i < 3000; i++) begin
            pix_ce = 1'b1;
            @(posedge board_clk); #1;
        end
        pix_ce = 1'b0;
        @(posedge board_clk); #1;
        chk("t5_rx_x_sat", 32'(rx_x), 2047);
        chk("t5_rx_y", 32'(rx_y), 0);
        chk("t5_locked", 32'(locked), 0);
        chk("t5_count", 32'(err_count), 0);
        restart_gen();
        advance(0, 0, 2);
        chk("t5_h_meas_sat", 32'(h_meas), 2047);
        chk("t5_rx_x_restart", 32'(rx_x), 0);
        chk("t5_locked_after", 32'(locked), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
